// File: rtl/scaler_up_pkg.sv
// scaler_up_pkg: shared defaults and saturation helper for the widening scaler.
package scaler_up_pkg;
    localparam int DEF_IN_WIDTH    = 8;
    localparam int DEF_OUT_WIDTH   = 14;
    localparam int DEF_SCALE_WIDTH = 4;
    localparam int DEF_WIN_LEN     = 1024;
    localparam int DEF_CNT_WIDTH   = 16;

    // Symmetric limit; the most-negative code is deliberately never produced.
    function automatic int sat_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction
endpackage

// File: rtl/scaler_up_if.sv
// scaler_up_if: narrow sample in, scaled/saturated sample out.
interface scaler_up_if
    import scaler_up_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) ();
    logic signed [IN_WIDTH-1:0]  in;
    logic                        in_valid;
    logic signed [OUT_WIDTH-1:0] out;
    logic                        out_valid;
    logic                        clip;
    modport master(output in, in_valid, input out, out_valid, clip);
    modport slave(input in, in_valid, output out, out_valid, clip);
endinterface

// File: rtl/scaler_up_peak_hold.sv
// scaler_up_peak_hold: max |value| over each WIN_LEN valid samples, with an update strobe.
module scaler_up_peak_hold
    import scaler_up_pkg::*;
#(
    parameter int WIDTH   = DEF_OUT_WIDTH,
    parameter int WIN_LEN = DEF_WIN_LEN
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    valid,
    input  logic signed [WIDTH-1:0] value,
    output logic        [WIDTH-2:0] peak,
    output logic                    peak_valid
);
    localparam int CW = $clog2(WIN_LEN);
    logic        [CW-1:0]    cnt;
    logic        [WIDTH-2:0] run_max, mag, nxt;
    logic signed [WIDTH-1:0] neg;
    logic                    last;
    assign neg  = -value;
    assign mag  = value[WIDTH-1] ? neg[WIDTH-2:0] : value[WIDTH-2:0];
    assign nxt  = mag > run_max ? mag : run_max;
    assign last = cnt == CW'(WIN_LEN - 1);
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt        <= '0;
            run_max    <= '0;
            peak       <= '0;
            peak_valid <= 1'b0;
        end else begin
            peak_valid <= valid && last;
            if (valid) begin
                cnt     <= last ? '0 : cnt + CW'(1);
                run_max <= last ? '0 : nxt;
                if (last) peak <= nxt;
            end
        end
    end
endmodule

// File: rtl/scaler_up.sv
// scaler_up: programmable left shift of narrow signed samples with symmetric saturation.
module scaler_up
    import scaler_up_pkg::*;
#(
    parameter int IN_WIDTH    = DEF_IN_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int SCALE_WIDTH = DEF_SCALE_WIDTH,
    parameter int WIN_LEN     = DEF_WIN_LEN,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   resetn,
    scaler_up_if.slave             smp,
    input  logic [SCALE_WIDTH-1:0] scale_in,
    input  logic                   scale_upd,
    input  logic                   cnt_clr,
    output logic [CNT_WIDTH-1:0]   clip_cnt,
    output logic [OUT_WIDTH-2:0]   peak,
    output logic                   peak_valid
);
    localparam int WW = IN_WIDTH + 2**SCALE_WIDTH - 1;
    localparam logic signed [WW-1:0] MAX = WW'(sat_max(OUT_WIDTH));
    localparam logic signed [WW-1:0] MIN = -MAX;

    logic        [SCALE_WIDTH-1:0] scale_q;
    logic signed [WW-1:0]          ext, wide_q;
    logic                          v1_q, hi, lo;

    assign ext = {{(WW - IN_WIDTH){smp.in[IN_WIDTH-1]}}, smp.in};
    assign hi  = wide_q > MAX;
    assign lo  = wide_q < MIN;

    // The sample accepted alongside scale_upd still sees the old scale.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            scale_q <= '0;
            wide_q  <= '0;
            v1_q    <= 1'b0;
        end else begin
            v1_q <= smp.in_valid;
            if (scale_upd) scale_q <= scale_in;
            if (smp.in_valid) wide_q <= ext <<< scale_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            smp.out       <= '0;
            smp.out_valid <= 1'b0;
            smp.clip      <= 1'b0;
        end else begin
            smp.out_valid <= v1_q;
            smp.clip      <= v1_q && (hi || lo);
            if (v1_q) smp.out <= hi ? MAX[OUT_WIDTH-1:0] : lo ? MIN[OUT_WIDTH-1:0] : wide_q[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || cnt_clr) clip_cnt <= '0;
        else if (smp.out_valid && smp.clip && !(&clip_cnt)) clip_cnt <= clip_cnt + CNT_WIDTH'(1);
    end

    scaler_up_peak_hold #(.WIDTH(OUT_WIDTH), .WIN_LEN(WIN_LEN)) u_peak (
        .clk        (clk),
        .resetn     (resetn),
        .valid      (smp.out_valid),
        .value      (smp.out),
        .peak       (peak),
        .peak_valid (peak_valid)
    );
endmodule

// File: tb/tb_scaler_up.sv
// tb_scaler_up: directed checks of shift, saturation, clip count, windowed peak and reset.
module tb_scaler_up;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  scale_in = '0;
    logic        scale_upd = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [15:0] clip_cnt;
    logic [12:0] peak;
    logic        peak_valid;
    int          n_checks = 0;
    int          n_fail = 0;

    scaler_up_if #(.IN_WIDTH(8), .OUT_WIDTH(14)) smp ();

    scaler_up #(.IN_WIDTH(8), .OUT_WIDTH(14), .SCALE_WIDTH(4), .WIN_LEN(4), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .smp        (smp),
        .scale_in   (scale_in),
        .scale_upd  (scale_upd),
        .cnt_clr    (cnt_clr),
        .clip_cnt   (clip_cnt),
        .peak       (peak),
        .peak_valid (peak_valid)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        smp.in_valid = 1'b0;
        scale_upd = 1'b0;
        cnt_clr = 1'b0;
        cyc(2);
        resetn = 1'b1;
    endtask

    task automatic set_scale(input int s);
        scale_in = 4'(s);
        scale_upd = 1'b1;
        cyc();
        scale_upd = 1'b0;
    endtask

    task automatic send(input int v);
        smp.in = 8'(v);
        smp.in_valid = 1'b1;
        cyc();
        smp.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        smp.in = '0;
        smp.in_valid = 1'b0;
        do_reset();
        n_checks++; if (smp.out !== 14'sd0) begin n_fail++; $display("FAIL reset_out got %0d exp 0", smp.out); end
        n_checks++; if (smp.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", smp.out_valid); end
        n_checks++; if (smp.clip !== 1'b0) begin n_fail++; $display("FAIL reset_clip got %b exp 0", smp.clip); end
        n_checks++; if (clip_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_clip_cnt got %0d exp 0", clip_cnt); end
        n_checks++; if (peak !== 13'd0) begin n_fail++; $display("FAIL reset_peak got %0d exp 0", peak); end
        n_checks++; if (peak_valid !== 1'b0) begin n_fail++; $display("FAIL reset_peak_valid got %b exp 0", peak_valid); end
    endtask

    task automatic test_shift();
        set_scale(6);
        send(127);
        n_checks++; if (smp.out_valid !== 1'b0) begin n_fail++; $display("FAIL shift_latency1 out_valid got %b exp 0", smp.out_valid); end
        cyc();
        n_checks++; if (smp.out !== 8128 || smp.out_valid !== 1'b1 || smp.clip !== 1'b0)
            begin n_fail++; $display("FAIL shift_127_s6 got %0d v%b c%b exp 8128 v1 c0", smp.out, smp.out_valid, smp.clip); end
        set_scale(3);
        send(-1);
        cyc();
        n_checks++; if (smp.out !== -8 || smp.clip !== 1'b0) begin n_fail++; $display("FAIL shift_m1_s3 got %0d c%b exp -8 c0", smp.out, smp.clip); end
    endtask

    task automatic test_saturate();
        do_reset();
        set_scale(6);
        send(-128);
        cyc();
        n_checks++; if (smp.out !== -8191 || smp.clip !== 1'b1) begin n_fail++; $display("FAIL sat_neg got %0d c%b exp -8191 c1", smp.out, smp.clip); end
        cyc();
        n_checks++; if (clip_cnt !== 16'd1) begin n_fail++; $display("FAIL sat_clip_cnt got %0d exp 1", clip_cnt); end
        set_scale(7);
        send(64);
        cyc();
        n_checks++; if (smp.out !== 8191 || smp.clip !== 1'b1) begin n_fail++; $display("FAIL sat_pos got %0d c%b exp 8191 c1", smp.out, smp.clip); end
        cyc();
        n_checks++; if (clip_cnt !== 16'd2) begin n_fail++; $display("FAIL sat_clip_cnt2 got %0d exp 2", clip_cnt); end
    endtask

    task automatic test_scale_update();
        do_reset();
        smp.in = 8'd10;
        smp.in_valid = 1'b1;
        scale_in = 4'd5;
        scale_upd = 1'b1;
        cyc();
        scale_upd = 1'b0;
        cyc();
        smp.in_valid = 1'b0;
        n_checks++; if (smp.out !== 10 || smp.out_valid !== 1'b1) begin n_fail++; $display("FAIL scale_old got %0d v%b exp 10 v1", smp.out, smp.out_valid); end
        cyc();
        n_checks++; if (smp.out !== 320 || smp.out_valid !== 1'b1) begin n_fail++; $display("FAIL scale_new got %0d v%b exp 320 v1", smp.out, smp.out_valid); end
        cyc();
        n_checks++; if (smp.out !== 320 || smp.out_valid !== 1'b0 || smp.clip !== 1'b0)
            begin n_fail++; $display("FAIL idle_hold got %0d v%b c%b exp 320 v0 c0", smp.out, smp.out_valid, smp.clip); end
    endtask

    task automatic test_back_to_back_peak();
        int ins[4] = '{5, -75, 20, 7};
        int scs[4] = '{2, 0, 0, 0};
        int pulses = 0;
        int pk = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            smp.in = 8'(ins[i]);
            smp.in_valid = 1'b1;
            scale_in = 4'(scs[i]);
            scale_upd = (i < 2);
            cyc();
            if (peak_valid) begin pulses++; pk = int'(peak); end
        end
        smp.in_valid = 1'b0;
        scale_upd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (peak_valid) begin pulses++; pk = int'(peak); end
        end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL peak_pulses got %0d exp 1", pulses); end
        n_checks++; if (pk !== 300) begin n_fail++; $display("FAIL peak_win1 got %0d exp 300", pk); end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            smp.in = 8'sd1;
            smp.in_valid = 1'b1;
            cyc();
            if (peak_valid) begin pulses++; pk = int'(peak); end
        end
        smp.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (peak_valid) begin pulses++; pk = int'(peak); end
        end
        n_checks++; if (pulses !== 1 || pk !== 1) begin n_fail++; $display("FAIL peak_win2 got %0d pulses %0d exp 1 pulses 1", pk, pulses); end
    endtask

    task automatic test_clip_cnt_sat();
        do_reset();
        set_scale(15);
        smp.in = 8'sd127;
        smp.in_valid = 1'b1;
        cyc(65540);
        n_checks++; if (clip_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL clip_cnt_sat got %h exp ffff", clip_cnt); end
        cyc(3);
        n_checks++; if (clip_cnt !== 16'hFFFF || smp.out !== 8191) begin n_fail++; $display("FAIL clip_cnt_hold got %h out %0d exp ffff 8191", clip_cnt, smp.out); end
        n_checks++; if (smp.clip !== 1'b1) begin n_fail++; $display("FAIL clip_before_clr got %b exp 1", smp.clip); end
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        n_checks++; if (clip_cnt !== 16'd0) begin n_fail++; $display("FAIL clip_cnt_clr got %0d exp 0", clip_cnt); end
        smp.in_valid = 1'b0;
        cyc(3);
    endtask

    task automatic test_reset_mid_stream();
        int ins[4] = '{3, 9, 2, 1};
        int pulses = 0;
        int pulse_at = -1;
        int pk = 0;
        do_reset();
        set_scale(7);
        smp.in = 8'sd100;
        smp.in_valid = 1'b1;
        cyc(6);
        n_checks++; if (peak !== 13'd8191) begin n_fail++; $display("FAIL pre_reset_peak got %0d exp 8191", peak); end
        resetn = 1'b0;
        cyc();
        smp.in_valid = 1'b0;
        n_checks++; if (smp.out !== 0 || smp.out_valid !== 1'b0 || smp.clip !== 1'b0 || clip_cnt !== 16'd0 || peak !== 13'd0 || peak_valid !== 1'b0)
            begin n_fail++; $display("FAIL mid_reset got out %0d v%b c%b cnt %0d pk %0d pv%b exp all 0", smp.out, smp.out_valid, smp.clip, clip_cnt, peak, peak_valid); end
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            smp.in = 8'(i < 4 ? ins[i] : 0);
            smp.in_valid = (i < 4);
            cyc();
            if (i == 1) begin
                n_checks++; if (smp.out !== 3) begin n_fail++; $display("FAIL post_reset_scale got %0d exp 3", smp.out); end
            end
            if (peak_valid) begin pulses++; pulse_at = i; pk = int'(peak); end
        end
        n_checks++; if (pulses !== 1 || pulse_at !== 5 || pk !== 9)
            begin n_fail++; $display("FAIL post_reset_window got pk %0d at %0d pulses %0d exp 9 at 5 pulses 1", pk, pulse_at, pulses); end
    endtask

    task automatic test_round_trip();
        int xs[6] = '{8000, 5657, 0, -5657, -8000, -77};
        int d;
        int o;
        int diff;
        set_scale(6);
        for (int i = 0; i < 6; i++) begin
            d = xs[i] >>> 6;
            send(d);
            cyc();
            o = int'(smp.out);
            diff = o > xs[i] ? o - xs[i] : xs[i] - o;
            n_checks++; if (o !== d * 64 || diff >= 64) begin n_fail++; $display("FAIL round_trip[%0d] got %0d exp %0d from %0d", i, o, d * 64, xs[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_saturate();
        test_scale_update();
        test_back_to_back_peak();
        test_clip_cnt_sat();
        test_reset_mid_stream();
        test_round_trip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
